// File: rtl/cv32e40p_mem_bridge_if.sv
// Bundles the instruction/data request-grant ports and the single-port SRAM port of cv32e40p_mem_bridge.
// The bridge connects to the slave modport; the environment that drives the core side and models the SRAM uses master.
interface cv32e40p_mem_bridge_if #(
  parameter int AW = 14
);
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic          sram_req_o;
  logic          sram_we_o;
  logic [3:0]    sram_be_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_wdata_o;
  logic [31:0]   sram_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  sram_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output sram_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/cv32e40p_mem_bridge.sv
// Arbitrates the core's instruction and data ports onto one single-port SRAM with optional grant wait states.
// Define CV32E40P_MEM_BRIDGE_RANGE_CHECK_EN to flag accesses beyond the SRAM with err instead of wrapping.
module cv32e40p_mem_bridge #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_STATES = 0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cv32e40p_mem_bridge_if.slave bus
);
  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        lock_data_q, lock_data_d;
  logic        last_data_q;
  logic        ready_q;
  logic        pick_data;
  logic        grant, grant_data;
  logic        instr_gnt, data_gnt;
  logic        in_range;
  logic [31:0] sel_addr;
  logic        instr_rv_q, data_rv_q, rv_zero_q;
  logic [31:0] instr_hold_q, data_hold_q, resp_data;
  logic        unused_addr_bits;

  // On a tie the port that did not win last time goes next.
  assign pick_data = bus.data_req_i & (~bus.instr_req_i | ~last_data_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_data_d = lock_data_q;
    grant       = 1'b0;
    grant_data  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && (bus.instr_req_i || bus.data_req_i)) begin
          if (WAIT_STATES == 0) begin
            grant      = 1'b1;
            grant_data = pick_data;
          end else begin
            state_d     = WAIT;
            cnt_d       = WS;
            lock_data_d = pick_data;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          grant      = 1'b1;
          grant_data = lock_data_q;
          cnt_d      = 3'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_gnt = grant & ~grant_data;
  assign data_gnt  = grant & grant_data;
  assign sel_addr  = grant_data ? bus.data_addr_i : bus.instr_addr_i;

`ifdef CV32E40P_MEM_BRIDGE_RANGE_CHECK_EN
  assign in_range = (sel_addr >> (AW + 2)) == 32'd0;
`else
  assign in_range = 1'b1;
`endif

  // Byte-offset bits and, when wrapping, the bits above the SRAM size carry no information here.
  assign unused_addr_bits = ^{sel_addr[31:AW+2], sel_addr[1:0]};

  assign bus.instr_gnt_o  = instr_gnt;
  assign bus.data_gnt_o   = data_gnt;
  assign bus.sram_req_o   = grant & in_range;
  assign bus.sram_addr_o  = grant ? sel_addr[AW+1:2] : '0;
  assign bus.sram_we_o    = data_gnt & bus.data_we_i;
  assign bus.sram_be_o    = !grant ? 4'h0 : (grant_data ? bus.data_be_i : 4'hF);
  assign bus.sram_wdata_o = data_gnt ? bus.data_wdata_i : 32'h0;

  // NOTE: reset is asynchronous and clears every register, including the rdata hold registers, because their value is visible on the ports.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q      <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      lock_data_q  <= 1'b0;
      last_data_q  <= 1'b1;
      instr_rv_q   <= 1'b0;
      data_rv_q    <= 1'b0;
      rv_zero_q    <= 1'b0;
      instr_hold_q <= 32'h0;
      data_hold_q  <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      ready_q     <= 1'b1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_data_q <= lock_data_d;
      if (grant) last_data_q <= grant_data;
      instr_rv_q  <= instr_gnt;
      data_rv_q   <= data_gnt;
      rv_zero_q   <= ~in_range | (grant_data & bus.data_we_i);
      if (instr_rv_q) instr_hold_q <= resp_data;
      if (data_rv_q)  data_hold_q  <= resp_data;
    end
  end

  // SRAM read data is only valid in the rvalid cycle, so it is passed through then and held afterwards.
  assign resp_data          = rv_zero_q ? 32'h0 : bus.sram_rdata_i;
  assign bus.instr_rvalid_o = instr_rv_q;
  assign bus.data_rvalid_o  = data_rv_q;
  assign bus.instr_rdata_o  = instr_rv_q ? resp_data : instr_hold_q;
  assign bus.data_rdata_o   = data_rv_q ? resp_data : data_hold_q;

`ifdef CV32E40P_MEM_BRIDGE_RANGE_CHECK_EN
  logic rv_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rv_err_q <= 1'b0;
    else       rv_err_q <= ~in_range;
  end

  assign bus.instr_err_o = instr_rv_q & rv_err_q;
  assign bus.data_err_o  = data_rv_q & rv_err_q;
`else
  assign bus.instr_err_o = 1'b0;
  assign bus.data_err_o  = 1'b0;
`endif

endmodule
